// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control unit: step states, opcode
// values, IR field positions and op-class helpers.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RST,
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_HALT
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    function automatic logic is_binary(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR,
            OP_ROL, OP_AND, OP_OR, OP_MUL, OP_DIV: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    function automatic logic is_unary(input logic [4:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/control_sequencer_reg_select_decoder.sv
// 4-to-NREGS one-hot register select; all zero when disabled.
module reg_select_decoder #(
    parameter int NREGS = 16
) (
    input  logic [3:0]       idx,
    input  logic             en,
    output logic [NREGS-1:0] onehot
);

    for (genvar g = 0; g < NREGS; g++) begin : g_bit
        assign onehot[g] = en && (idx == 4'(g));
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute step sequencer for the single-bus datapath;
// strobes are a combinational decode of the step state and IR.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int NREGS = 16
) (
    input  logic             Clock,
    input  logic             clear,
    input  logic             run,
    input  logic             mem_ready,
    input  logic [31:0]      IR,
    output logic [NREGS-1:0] Rin,
    output logic [NREGS-1:0] Rout,
    output logic             PCout,
    output logic             PCin,
    output logic             IncPC,
    output logic             MARin,
    output logic             MDRin,
    output logic             MDRout,
    output logic             Read,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             HIin,
    output logic             LOin,
    output logic [4:0]       opcode,
    output logic             halted,
    output logic             illegal_op
);

    state_t     state_q, state_d;
    logic       t1_stall_q;
    logic [4:0] ir_op;
    logic [3:0] ra, rb, rc;
    logic       op_bin, op_un, op_md, op_halt;
    logic       rin_en, rout_en;
    logic [3:0] rin_idx, rout_idx;
    state_t     after_exec;
    logic       unused_ir;

    assign ir_op     = IR[OPC_MSB:OPC_LSB];
    assign ra        = IR[RA_MSB:RA_LSB];
    assign rb        = IR[RB_MSB:RB_LSB];
    assign rc        = IR[RC_MSB:RC_LSB];
    assign unused_ir = ^IR[RC_LSB-1:0];

    assign op_bin  = is_binary(ir_op);
    assign op_un   = is_unary(ir_op);
    assign op_md   = is_muldiv(ir_op);
    assign op_halt = (ir_op == OP_HALT);

    // run only matters on the way into T0
    assign after_exec = run ? ST_T0 : ST_IDLE;

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state_q    <= ST_RST;
            t1_stall_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            t1_stall_q <= (state_q == ST_T1) && !mem_ready;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST:  state_d = after_exec;
            ST_IDLE: if (run) state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
            ST_T1:   if (mem_ready) state_d = ST_T2;
            ST_T2:   state_d = ST_T3;
            ST_T3: begin
                if (op_halt)              state_d = ST_HALT;
                else if (op_bin || op_un) state_d = ST_T4;
                else                      state_d = after_exec;
            end
            ST_T4:   state_d = ST_T5;
            ST_T5:   state_d = op_md ? ST_T6 : after_exec;
            ST_T6:   state_d = after_exec;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase
    end

    always_comb begin
        PCout      = 1'b0;
        PCin       = 1'b0;
        IncPC      = 1'b0;
        MARin      = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        Read       = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        Zin        = 1'b0;
        Zlowout    = 1'b0;
        Zhighout   = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        opcode     = 5'b00000;
        illegal_op = 1'b0;
        rin_en     = 1'b0;
        rin_idx    = ra;
        rout_en    = 1'b0;
        rout_idx   = rb;
        case (state_q)
            ST_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            ST_T1: begin
                // PC reload happens once; a memory stall only holds the read
                Zlowout = 1'b1;
                PCin    = !t1_stall_q;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: begin
                if (op_bin) begin
                    rout_en = 1'b1;
                    Yin     = 1'b1;
                end else if (!op_un && !op_halt) begin
                    illegal_op = 1'b1;
                end
            end
            ST_T4: begin
                Zin      = 1'b1;
                opcode   = ir_op;
                rout_en  = op_bin || op_un;
                rout_idx = op_bin ? rc : rb;
            end
            ST_T5: begin
                Zlowout = 1'b1;
                LOin    = op_md;
                rin_en  = !op_md;
            end
            ST_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            default: ;
        endcase
    end

    assign halted = (state_q == ST_HALT);

    reg_select_decoder #(.NREGS(NREGS)) u_rin_dec (
        .idx    (rin_idx),
        .en     (rin_en),
        .onehot (Rin)
    );

    reg_select_decoder #(.NREGS(NREGS)) u_rout_dec (
        .idx    (rout_idx),
        .en     (rout_en),
        .onehot (Rout)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-instruction expected strobe sequences
// are generated from the step rules and compared cycle by cycle.
module tb_control_sequencer;

    localparam int NREGS = 16;

    localparam int B_PCOUT = 13, B_PCIN = 12, B_INCPC = 11, B_MARIN = 10;
    localparam int B_MDRIN = 9, B_MDROUT = 8, B_READ = 7, B_IRIN = 6;
    localparam int B_YIN = 5, B_ZIN = 4, B_ZLO = 3, B_ZHI = 2, B_HIIN = 1, B_LOIN = 0;

    logic             Clock = 1'b0;
    logic             clear, run, mem_ready;
    logic [31:0]      IR;
    logic [NREGS-1:0] Rin, Rout;
    logic             PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin;
    logic             Yin, Zin, Zlowout, Zhighout, HIin, LOin;
    logic [4:0]       opcode;
    logic             halted, illegal_op;

    always #5 Clock = ~Clock;

    control_sequencer #(.NREGS(NREGS)) dut (
        .Clock      (Clock),
        .clear      (clear),
        .run        (run),
        .mem_ready  (mem_ready),
        .IR         (IR),
        .Rin        (Rin),
        .Rout       (Rout),
        .PCout      (PCout),
        .PCin       (PCin),
        .IncPC      (IncPC),
        .MARin      (MARin),
        .MDRin      (MDRin),
        .MDRout     (MDRout),
        .Read       (Read),
        .IRin       (IRin),
        .Yin        (Yin),
        .Zin        (Zin),
        .Zlowout    (Zlowout),
        .Zhighout   (Zhighout),
        .HIin       (HIin),
        .LOin       (LOin),
        .opcode     (opcode),
        .halted     (halted),
        .illegal_op (illegal_op)
    );

    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic [13:0] strb;
        logic [4:0]  opc;
        logic        halted;
        logic        illegal;
    } obs_t;

    obs_t eq[$];
    bit   mq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic obs_t observe();
        obs_t o;
        o.rin     = Rin;
        o.rout    = Rout;
        o.strb    = {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin,
                     Yin, Zin, Zlowout, Zhighout, HIin, LOin};
        o.opc     = opcode;
        o.halted  = halted;
        o.illegal = illegal_op;
        return o;
    endfunction

    task automatic tick(input bit mr);
        mem_ready = mr;
        @(posedge Clock);
        #1;
    endtask

    function automatic void push(input obs_t o, input bit mr);
        eq.push_back(o);
        mq.push_back(mr);
    endfunction

    // Expected per-cycle outputs of one instruction, starting with its T0 step.
    function automatic void build(input logic [31:0] ir, input int waits);
        obs_t       o;
        logic [4:0] op = ir[31:27];
        int         ra = int'(ir[26:23]);
        int         rb = int'(ir[22:19]);
        int         rc = int'(ir[18:15]);
        bit bin = op inside {5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd14, 5'd15};
        bit un  = op inside {5'd16, 5'd17};
        bit md  = op inside {5'd14, 5'd15};
        bit hlt = (op == 5'd27);
        o = '0;
        o.strb[B_PCOUT] = 1; o.strb[B_MARIN] = 1; o.strb[B_INCPC] = 1; o.strb[B_ZIN] = 1;
        push(o, 1'($urandom_range(0, 1)));
        for (int w = 0; w <= waits; w++) begin
            o = '0;
            o.strb[B_ZLO] = 1; o.strb[B_READ] = 1; o.strb[B_MDRIN] = 1;
            o.strb[B_PCIN] = (w == 0);
            push(o, w == waits);
        end
        o = '0;
        o.strb[B_MDROUT] = 1; o.strb[B_IRIN] = 1;
        push(o, 1'($urandom_range(0, 1)));
        o = '0;
        if (bin) begin
            o.rout = 16'(1) << rb;
            o.strb[B_YIN] = 1;
        end else if (!un && !hlt) begin
            o.illegal = 1;
        end
        push(o, 1'($urandom_range(0, 1)));
        if (bin || un) begin
            o = '0;
            o.strb[B_ZIN] = 1;
            o.opc  = op;
            o.rout = 16'(1) << (bin ? rc : rb);
            push(o, 1'($urandom_range(0, 1)));
            o = '0;
            o.strb[B_ZLO] = 1;
            if (md) o.strb[B_LOIN] = 1;
            else    o.rin = 16'(1) << ra;
            push(o, 1'($urandom_range(0, 1)));
            if (md) begin
                o = '0;
                o.strb[B_ZHI] = 1; o.strb[B_HIIN] = 1;
                push(o, 1'($urandom_range(0, 1)));
            end
        end
    endfunction

    task automatic test_reset();
        obs_t o;
        @(posedge Clock); #1;
        o = observe(); checks++;
        if (o !== obs_t'(0)) begin errors++; $display("FAIL reset_hold got %h exp 0", o); end
        clear = 1'b1;
        tick(1'b0);
        o = observe(); checks++;
        if (o !== obs_t'(0)) begin errors++; $display("FAIL reset_idle got %h exp 0", o); end
        run = 1'b1;
        tick(1'b0);
    endtask

    task automatic test_fixed(input string name, input logic [31:0] ir, input int waits);
        obs_t o, e;
        bit   mr;
        int   n = 0;
        IR = ir;
        build(ir, waits);
        while (eq.size() > 0) begin
            e = eq.pop_front(); mr = mq.pop_front();
            o = observe(); checks++;
            if (o !== e) begin errors++; $display("FAIL %s cyc %0d got %h exp %h", name, n, o, e); end
            n++;
            tick(mr);
        end
    endtask

    task automatic test_run_idle();
        obs_t o, e;
        bit   mr;
        int   n = 0;
        IR = 32'h1A1A0000;
        build(IR, 1);
        for (int i = 0; i < 3; i++) push(obs_t'(0), 1'($urandom_range(0, 1)));
        while (eq.size() > 0) begin
            e = eq.pop_front(); mr = mq.pop_front();
            o = observe(); checks++;
            if (o !== e) begin errors++; $display("FAIL run_idle cyc %0d got %h exp %h", n, o, e); end
            if (n == 0) run = 1'b0;
            if (eq.size() == 0) run = 1'b1;
            n++;
            tick(mr);
        end
    endtask

    task automatic test_clear_mid();
        obs_t o, e;
        bit   mr;
        IR = 32'h18918000;
        build(IR, 0);
        for (int i = 0; i < 5; i++) begin
            e = eq.pop_front(); mr = mq.pop_front();
            o = observe(); checks++;
            if (o !== e) begin errors++; $display("FAIL clear_mid cyc %0d got %h exp %h", i, o, e); end
            if (i < 4) tick(mr);
        end
        eq.delete(); mq.delete();
        #2 clear = 1'b0;
        #1;
        o = observe(); checks++;
        if (o !== obs_t'(0)) begin errors++; $display("FAIL clear_async got %h exp 0", o); end
        @(posedge Clock); #1;
        o = observe(); checks++;
        if (o !== obs_t'(0)) begin errors++; $display("FAIL clear_held got %h exp 0", o); end
        clear = 1'b1;
        tick(1'b0);
    endtask

    task automatic test_random();
        logic [4:0]  ops[20] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd14, 5'd15,
                                 5'd16, 5'd17, 5'd0, 5'd1, 5'd2, 5'd11, 5'd12, 5'd13, 5'd18, 5'd31};
        logic [31:0] r;
        for (int k = 0; k < 30; k++) begin
            r = $urandom();
            test_fixed("random", {ops[$urandom_range(0, 19)], r[26:0]}, int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_halt();
        obs_t o, e;
        test_fixed("halt_fetch", 32'hD8000000, 0);
        e = '0;
        e.halted = 1'b1;
        for (int i = 0; i < 10; i++) begin
            o = observe(); checks++;
            if (o !== e) begin errors++; $display("FAIL halt_hold cyc %0d got %h exp %h", i, o, e); end
            run = 1'($urandom_range(0, 1));
            tick(1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        clear     = 1'b0;
        run       = 1'b0;
        mem_ready = 1'b0;
        IR        = 32'h0;
        test_reset();
        test_fixed("add", 32'h18918000, 0);
        test_fixed("neg", 32'h80900000, 0);
        test_fixed("mul", 32'h70118000, 0);
        test_fixed("stall", 32'h18918000, 3);
        test_fixed("illegal", 32'hF8000000, 0);
        test_run_idle();
        test_clear_mid();
        test_fixed("after_clear", 32'h18918000, 0);
        test_random();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
